// File: rtl/latch_bank_if.sv
// latch_bank_if: control, data and status bundle for latch_bank.
// The master drives gates/data/configuration; the slave returns held words and flags.
interface latch_bank_if #(
   parameter int LATCH_WIDTH = 4,
   parameter int CHANNELS    = 4,
   parameter int HOLD_W      = 4
);
   logic                            clr;
   logic                            mode;
   logic [HOLD_W-1:0]               hold;
   logic [CHANNELS-1:0]             g;
   logic [CHANNELS*LATCH_WIDTH-1:0] d;
   logic [CHANNELS*LATCH_WIDTH-1:0] q;
   logic [CHANNELS-1:0]             valid;
   logic [CHANNELS-1:0]             busy;
   logic [CHANNELS-1:0]             ovr;

   modport master (
      output clr, mode, hold, g, d,
      input  q, valid, busy, ovr
   );

   modport slave (
      input  clr, mode, hold, g, d,
      output q, valid, busy, ovr
   );
endinterface

// File: rtl/latch_bank.sv
// latch_bank: CHANNELS independent held words, captured in level or edge mode,
// each followed by a programmable hold-off lockout with sticky overrun reporting.
module latch_bank #(
   parameter int LATCH_WIDTH = 4,
   parameter int CHANNELS    = 4,
   parameter int HOLD_W      = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   latch_bank_if.slave bus
);
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_TRACK = 2'd1,
      ST_LOCK  = 2'd2,
      ST_HELD  = 2'd3
   } state_e;

   state_e                          r_state [CHANNELS];
   logic [HOLD_W-1:0]               r_cnt   [CHANNELS];
   logic [CHANNELS*LATCH_WIDTH-1:0] r_q;
   logic [CHANNELS-1:0]             r_g_d;
   logic [CHANNELS-1:0]             r_valid;
   logic [CHANNELS-1:0]             r_busy;
   logic [CHANNELS-1:0]             r_ovr;
   logic [CHANNELS-1:0]             w_rise;
   logic                            w_hold_zero;

   assign w_rise      = bus.g & ~r_g_d;
   assign w_hold_zero = (bus.hold == {HOLD_W{1'b0}});

   // Per-channel FSM; status flags are updated together with the state they decode.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q     <= '0;
         r_g_d   <= '0;
         r_valid <= '0;
         r_busy  <= '0;
         r_ovr   <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            r_state[k] <= ST_EMPTY;
            r_cnt[k]   <= '0;
         end
      end else if (bus.clr) begin
         r_q     <= '0;
         r_g_d   <= '0;
         r_valid <= '0;
         r_busy  <= '0;
         r_ovr   <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            r_state[k] <= ST_EMPTY;
            r_cnt[k]   <= '0;
         end
      end else begin
         r_g_d <= bus.g;
         for (int k = 0; k < CHANNELS; k++) begin
            case (r_state[k])
               ST_EMPTY, ST_HELD: begin
                  if (!bus.mode && bus.g[k]) begin
                     r_q[k*LATCH_WIDTH +: LATCH_WIDTH] <= bus.d[k*LATCH_WIDTH +: LATCH_WIDTH];
                     r_state[k] <= ST_TRACK;
                     r_valid[k] <= 1'b1;
                  end else if (bus.mode && w_rise[k]) begin
                     r_q[k*LATCH_WIDTH +: LATCH_WIDTH] <= bus.d[k*LATCH_WIDTH +: LATCH_WIDTH];
                     r_valid[k] <= 1'b1;
                     if (w_hold_zero) begin
                        r_state[k] <= ST_HELD;
                     end else begin
                        r_state[k] <= ST_LOCK;
                        r_cnt[k]   <= bus.hold;
                        r_busy[k]  <= 1'b1;
                     end
                  end else begin
                     r_state[k] <= r_state[k];
                  end
               end
               ST_TRACK: begin
                  // A mode switch while tracking freezes the last captured word.
                  if (bus.mode) begin
                     r_state[k] <= ST_HELD;
                  end else if (bus.g[k]) begin
                     r_q[k*LATCH_WIDTH +: LATCH_WIDTH] <= bus.d[k*LATCH_WIDTH +: LATCH_WIDTH];
                  end else if (w_hold_zero) begin
                     r_state[k] <= ST_HELD;
                  end else begin
                     r_state[k] <= ST_LOCK;
                     r_cnt[k]   <= bus.hold;
                     r_busy[k]  <= 1'b1;
                  end
               end
               ST_LOCK: begin
                  if ((!bus.mode && bus.g[k]) || (bus.mode && w_rise[k])) begin
                     r_ovr[k] <= 1'b1;
                  end else begin
                     r_ovr[k] <= r_ovr[k];
                  end
                  if (r_cnt[k] == HOLD_W'(1)) begin
                     r_state[k] <= ST_HELD;
                     r_busy[k]  <= 1'b0;
                  end else begin
                     r_cnt[k] <= r_cnt[k] - HOLD_W'(1);
                  end
               end
               default: begin
                  r_state[k] <= ST_EMPTY;
                  r_valid[k] <= 1'b0;
                  r_busy[k]  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.q     = r_q;
   assign bus.valid = r_valid;
   assign bus.busy  = r_busy;
   assign bus.ovr   = r_ovr;
endmodule

// File: tb/tb_latch_bank.sv
// tb_latch_bank: directed stimulus with a scoreboard of expected held words and flags,
// each popped and checked one cycle after the stimulus that produced it.
module tb_latch_bank;
   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct {
      string       tag;
      logic [15:0] q;
      logic [3:0]  v;
      logic [3:0]  b;
      logic [3:0]  o;
   } exp_t;

   exp_t sb[$];

   latch_bank_if #(.LATCH_WIDTH(4), .CHANNELS(4), .HOLD_W(4)) bus ();

   latch_bank #(.LATCH_WIDTH(4), .CHANNELS(4), .HOLD_W(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_front();
      exp_t e;
      n_tests++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         assert (bus.q === e.q) else begin
            n_fail++;
            $error("FAIL %s.q: observed %h expected %h", e.tag, bus.q, e.q);
         end
         n_tests++;
         assert (bus.valid === e.v) else begin
            n_fail++;
            $error("FAIL %s.valid: observed %b expected %b", e.tag, bus.valid, e.v);
         end
         n_tests++;
         assert (bus.busy === e.b) else begin
            n_fail++;
            $error("FAIL %s.busy: observed %b expected %b", e.tag, bus.busy, e.b);
         end
         n_tests++;
         assert (bus.ovr === e.o) else begin
            n_fail++;
            $error("FAIL %s.ovr: observed %b expected %b", e.tag, bus.ovr, e.o);
         end
      end
   endtask

   task automatic expect_now(input string tag, input logic [15:0] eq,
                             input logic [3:0] ev, input logic [3:0] eb, input logic [3:0] eo);
      sb.push_back('{tag, eq, ev, eb, eo});
      check_front();
   endtask

   task automatic step(input string tag, input logic c, input logic m, input logic [3:0] h,
                       input logic [3:0] gg, input logic [15:0] dd, input logic [15:0] eq,
                       input logic [3:0] ev, input logic [3:0] eb, input logic [3:0] eo);
      bus.clr  = c;
      bus.mode = m;
      bus.hold = h;
      bus.g    = gg;
      bus.d    = dd;
      sb.push_back('{tag, eq, ev, eb, eo});
      @(posedge clk);
      #1;
      check_front();
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.clr  = 1'b0;
      bus.mode = 1'b0;
      bus.hold = 4'd0;
      bus.g    = 4'b0000;
      bus.d    = 16'h0000;
      @(posedge clk);
      @(posedge clk);
      #1;
      expect_now("reset", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
      rst_n = 1'b1;

      // clear beats a same-cycle level capture
      step("clr_vs_g",  1'b1, 1'b0, 4'd0, 4'b0001, 16'h0001, 16'h0000, 4'b0000, 4'b0000, 4'b0000);

      // level mode, no hold-off
      step("lvl_d1",    1'b0, 1'b0, 4'd0, 4'b0001, 16'h0001, 16'h0001, 4'b0001, 4'b0000, 4'b0000);
      step("lvl_d2",    1'b0, 1'b0, 4'd0, 4'b0001, 16'h0002, 16'h0002, 4'b0001, 4'b0000, 4'b0000);
      step("lvl_d3",    1'b0, 1'b0, 4'd0, 4'b0001, 16'h0003, 16'h0003, 4'b0001, 4'b0000, 4'b0000);
      step("lvl_fall",  1'b0, 1'b0, 4'd0, 4'b0000, 16'h0009, 16'h0003, 4'b0001, 4'b0000, 4'b0000);
      step("lvl_hold",  1'b0, 1'b0, 4'd0, 4'b0000, 16'h0009, 16'h0003, 4'b0001, 4'b0000, 4'b0000);

      // level mode, HOLD=3 with gate activity inside the lockout
      step("l3_cap",    1'b0, 1'b0, 4'd3, 4'b0001, 16'h0004, 16'h0004, 4'b0001, 4'b0000, 4'b0000);
      step("l3_busy1",  1'b0, 1'b0, 4'd3, 4'b0000, 16'h0004, 16'h0004, 4'b0001, 4'b0001, 4'b0000);
      step("l3_busy2",  1'b0, 1'b0, 4'd3, 4'b0000, 16'h0004, 16'h0004, 4'b0001, 4'b0001, 4'b0000);
      step("l3_ovr",    1'b0, 1'b0, 4'd3, 4'b0001, 16'h000A, 16'h0004, 4'b0001, 4'b0001, 4'b0001);
      step("l3_end",    1'b0, 1'b0, 4'd3, 4'b0000, 16'h000A, 16'h0004, 4'b0001, 4'b0000, 4'b0001);
      step("l3_recap",  1'b0, 1'b0, 4'd3, 4'b0001, 16'h0005, 16'h0005, 4'b0001, 4'b0000, 4'b0001);
      step("l3_rel",    1'b0, 1'b0, 4'd0, 4'b0000, 16'h0005, 16'h0005, 4'b0001, 4'b0000, 4'b0001);
      step("clr_all",   1'b1, 1'b0, 4'd0, 4'b0000, 16'h0005, 16'h0000, 4'b0000, 4'b0000, 4'b0000);

      // edge mode, HOLD=2, gate held high
      step("e2_rise",   1'b0, 1'b1, 4'd2, 4'b0001, 16'h0000, 16'h0000, 4'b0001, 4'b0001, 4'b0000);
      step("e2_d1",     1'b0, 1'b1, 4'd2, 4'b0001, 16'h0001, 16'h0000, 4'b0001, 4'b0001, 4'b0000);
      step("e2_d2",     1'b0, 1'b1, 4'd2, 4'b0001, 16'h0002, 16'h0000, 4'b0001, 4'b0000, 4'b0000);
      step("e2_d3",     1'b0, 1'b1, 4'd2, 4'b0001, 16'h0003, 16'h0000, 4'b0001, 4'b0000, 4'b0000);
      step("e2_d4",     1'b0, 1'b1, 4'd2, 4'b0001, 16'h0004, 16'h0000, 4'b0001, 4'b0000, 4'b0000);
      step("e2_drop",   1'b0, 1'b1, 4'd2, 4'b0000, 16'h0004, 16'h0000, 4'b0001, 4'b0000, 4'b0000);
      step("e2_rise7",  1'b0, 1'b1, 4'd2, 4'b0001, 16'h0007, 16'h0007, 4'b0001, 4'b0001, 4'b0000);
      step("e2_lk",     1'b0, 1'b1, 4'd2, 4'b0000, 16'h0007, 16'h0007, 4'b0001, 4'b0001, 4'b0000);
      step("e2_done",   1'b0, 1'b1, 4'd2, 4'b0000, 16'h0007, 16'h0007, 4'b0001, 4'b0000, 4'b0000);

      // edge mode, HOLD=4, second rise two cycles after the first
      step("e4_rise",   1'b0, 1'b1, 4'd4, 4'b0001, 16'h0008, 16'h0008, 4'b0001, 4'b0001, 4'b0000);
      step("e4_low",    1'b0, 1'b1, 4'd4, 4'b0000, 16'h0008, 16'h0008, 4'b0001, 4'b0001, 4'b0000);
      step("e4_ovr",    1'b0, 1'b1, 4'd4, 4'b0001, 16'h000B, 16'h0008, 4'b0001, 4'b0001, 4'b0001);
      step("e4_lk",     1'b0, 1'b1, 4'd4, 4'b0001, 16'h000B, 16'h0008, 4'b0001, 4'b0001, 4'b0001);
      step("e4_done",   1'b0, 1'b1, 4'd4, 4'b0001, 16'h000B, 16'h0008, 4'b0001, 4'b0000, 4'b0001);

      // async reset in the middle of a lockout
      step("rl_low",    1'b0, 1'b1, 4'd4, 4'b0000, 16'h000C, 16'h0008, 4'b0001, 4'b0000, 4'b0001);
      step("rl_cap",    1'b0, 1'b1, 4'd4, 4'b0001, 16'h000C, 16'h000C, 4'b0001, 4'b0001, 4'b0001);
      #3;
      rst_n = 1'b0;
      #1;
      expect_now("async_rst", 16'h0000, 4'b0000, 4'b0000, 4'b0000);
      bus.mode = 1'b0;
      bus.hold = 4'd0;
      bus.g    = 4'b0000;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // channel independence with staggered gates
      step("ch_g0",     1'b0, 1'b0, 4'd0, 4'b0001, 16'h4321, 16'h0001, 4'b0001, 4'b0000, 4'b0000);
      step("ch_g2",     1'b0, 1'b0, 4'd0, 4'b0100, 16'h4321, 16'h0301, 4'b0101, 4'b0000, 4'b0000);
      step("ch_idle",   1'b0, 1'b0, 4'd0, 4'b0000, 16'h4321, 16'h0301, 4'b0101, 4'b0000, 4'b0000);
      step("ch_g3",     1'b0, 1'b0, 4'd0, 4'b1000, 16'h8765, 16'h8301, 4'b1101, 4'b0000, 4'b0000);
      step("ch_e1",     1'b0, 1'b1, 4'd1, 4'b0010, 16'h4321, 16'h8321, 4'b1111, 4'b0010, 4'b0000);
      step("ch_e1done", 1'b0, 1'b1, 4'd1, 4'b0010, 16'h4321, 16'h8321, 4'b1111, 4'b0000, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
